// File: rtl/clock_gate_ctrl_if.sv
// rtl/clock_gate_ctrl_if.sv - request/enable bundle between domain requesters and clock_gate_ctrl
// Optional CLOCK_GATE_CTRL_EVENT_CNT_EN adds the packed gateEvents counter vector.
interface clock_gate_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic [WIDTH-1:0] forceOn;
  logic [WIDTH-1:0] busy;
  logic [WIDTH-1:0] clkGate;
  logic [WIDTH-1:0] wakeAck;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
  logic [WIDTH*8-1:0] gateEvents;

  modport master (output enable, forceOn, busy, input clkGate, wakeAck, gateEvents);
  modport slave  (input enable, forceOn, busy, output clkGate, wakeAck, gateEvents);
`else
  modport master (output enable, forceOn, busy, input clkGate, wakeAck);
  modport slave  (input enable, forceOn, busy, output clkGate, wakeAck);
`endif
endinterface

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - per-domain idle clock-gate enable generator with wake acknowledge
// Optional CLOCK_GATE_CTRL_EVENT_CNT_EN adds 8-bit saturating gate-off event counters.
module clock_gate_ctrl #(
  parameter int WIDTH       = 3,
  parameter int IDLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  clock_gate_ctrl_if.slave gateIf
);
  localparam int                CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ON   = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } state_t;

  logic [WIDTH-1:0] gateVec;
  logic [WIDTH-1:0] ackVec;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
  logic [WIDTH*8-1:0] eventVec;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : gChan
    state_t           state;
    logic [CNT_W-1:0] idleCnt;
    logic             ackQ;
    logic             gateQ;
    logic             hold;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
    logic [7:0]       evCnt;
`endif

    assign hold = !gateIf.enable || gateIf.forceOn[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= ON;
        idleCnt <= '0;
        ackQ    <= 1'b0;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
        evCnt   <= 8'd0;
`endif
      end else begin
        ackQ <= 1'b0;
        case (state)
          ON: begin
            // busy or hold on the terminal-count edge keeps the channel on
            if (gateIf.busy[i] || hold) begin
              idleCnt <= '0;
            end else if (idleCnt == TERM) begin
              state   <= OFF;
              idleCnt <= '0;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
              if (evCnt != 8'hFF) evCnt <= evCnt + 8'd1;
`endif
            end else begin
              idleCnt <= idleCnt + CNT_W'(1);
            end
          end
          OFF: begin
            if (gateIf.busy[i] || hold) begin
              state <= WAKE;
              ackQ  <= 1'b1;
            end
          end
          WAKE: begin
            state   <= ON;
            idleCnt <= '0;
          end
          default: begin
            state   <= ON;
            idleCnt <= '0;
          end
        endcase
      end
    end

    // Retimed to the falling edge so the downstream AND gate only sees changes while clk is low
    always_ff @(negedge clk or posedge rst) begin
      if (rst) gateQ <= 1'b1;
      else     gateQ <= (state != OFF);
    end

    assign gateVec[i] = gateQ;
    assign ackVec[i]  = ackQ;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
    assign eventVec[i*8 +: 8] = evCnt;
`endif
  end

  assign gateIf.clkGate = gateVec;
  assign gateIf.wakeAck = ackVec;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
  assign gateIf.gateEvents = eventVec;
`endif
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - scoreboard bench for clock_gate_ctrl (WIDTH=3, IDLE_CYCLES=4)
// Also covers the CLOCK_GATE_CTRL_EVENT_CNT_EN counters when that macro is defined.
module tb_clock_gate_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = -1;
  int   total = 0;
  int   bad = 0;
  event chkNow;

  typedef struct {
    int         cyc;
    logic [2:0] gate;
    logic [2:0] ack;
  } exp_t;

  exp_t sb[$];

  clock_gate_ctrl_if #(.WIDTH(3)) gif ();

  clock_gate_ctrl #(
    .WIDTH      (3),
    .IDLE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .gateIf(gif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int c, input logic [2:0] g, input logic [2:0] a);
    exp_t e;
    e.cyc  = c;
    e.gate = g;
    e.ack  = a;
    sb.push_back(e);
  endtask

  task automatic expRange(input int c0, input int c1, input logic [2:0] g, input logic [2:0] a);
    for (int c = c0; c <= c1; c++) push(c, g, a);
  endtask

  // Returns in the low phase just before posedge n, so new inputs are sampled at edge n
  task automatic atEdge(input int n);
    while (cyc < n - 1) @(negedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chkNow);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk($sformatf("clkGate@%0d", e.cyc), {29'd0, gif.clkGate}, {29'd0, e.gate});
        chk($sformatf("wakeAck@%0d", e.cyc), {29'd0, gif.wakeAck}, {29'd0, e.ack});
      end
    end
  end

  always @(gif.clkGate) begin
    if (rst === 1'b0) chk("gateEdgeClkLow", {31'd0, clk}, 32'd0);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    gif.enable = 1'b1;
    gif.forceOn = 3'b000;
    gif.busy = 3'b111;
    #1;
    push(cyc, 3'b111, 3'b000);
    ->chkNow;
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
    chk("eventsAtReset", {8'd0, gif.gateEvents}, 32'd0);
`endif
    atEdge(2);
    rst = 1'b0;
    expRange(2, 13, 3'b111, 3'b000);
    expRange(14, 19, 3'b000, 3'b000);

    atEdge(11);
    gif.busy = 3'b000;

    atEdge(20);
    gif.busy = 3'b010;
    push(20, 3'b010, 3'b010);
    expRange(21, 23, 3'b010, 3'b000);

    atEdge(24);
    gif.busy = 3'b011;
    push(24, 3'b011, 3'b001);

    atEdge(25);
    gif.busy = 3'b010;
    expRange(25, 36, 3'b011, 3'b000);
    expRange(37, 39, 3'b010, 3'b000);
    atEdge(29);
    gif.busy = 3'b011;
    atEdge(30);
    gif.busy = 3'b010;
    atEdge(33);
    gif.busy = 3'b011;
    atEdge(34);
    gif.busy = 3'b010;

    atEdge(40);
    gif.forceOn = 3'b100;
    push(40, 3'b110, 3'b100);
    push(41, 3'b110, 3'b000);
    atEdge(42);
    gif.busy = 3'b000;
    expRange(42, 48, 3'b110, 3'b000);
    push(49, 3'b100, 3'b000);
    atEdge(45);
    gif.forceOn = 3'b110;
    atEdge(46);
    gif.forceOn = 3'b100;

    atEdge(50);
    gif.enable = 1'b0;
    push(50, 3'b111, 3'b011);
    expRange(51, 59, 3'b111, 3'b000);

    atEdge(60);
    gif.enable = 1'b1;
    gif.forceOn = 3'b000;
    expRange(60, 62, 3'b111, 3'b000);
    expRange(63, 65, 3'b000, 3'b000);

    atEdge(66);
    gif.busy = 3'b001;
    @(posedge clk);
    #2;
    rst = 1'b1;
    gif.busy = 3'b000;
    #1;
    push(cyc, 3'b111, 3'b000);
    ->chkNow;
    push(67, 3'b111, 3'b000);
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
    chk("eventsMidReset", {8'd0, gif.gateEvents}, 32'd0);
`endif
    atEdge(68);
    rst = 1'b0;
    expRange(68, 70, 3'b111, 3'b000);
    expRange(71, 72, 3'b000, 3'b000);

    atEdge(74);
`ifdef CLOCK_GATE_CTRL_EVENT_CNT_EN
    chk("eventsAfterOneGate", {8'd0, gif.gateEvents}, {8'd0, 8'd1, 8'd1, 8'd1});
    for (int k = 0; k < 300; k++) begin
      int w;
      w = 0;
      while (gif.clkGate[0] !== 1'b0 && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      if (w >= 20) begin
        chk("gateOffTimeout", {31'd0, gif.clkGate[0]}, 32'd0);
        break;
      end
      gif.busy = 3'b001;
      @(negedge clk);
      #1;
      gif.busy = 3'b000;
    end
    repeat (8) @(negedge clk);
    #1;
    chk("eventsCh0Saturated", {24'd0, gif.gateEvents[7:0]}, 32'd255);
    chk("eventsCh1", {24'd0, gif.gateEvents[15:8]}, 32'd1);
    chk("eventsCh2", {24'd0, gif.gateEvents[23:16]}, 32'd1);
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    #3;
    if (sb.size() > 0) chk("scoreboardDrained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
